// File: rtl/interval_sched_pkg.sv
// ----------------------------------------------------------------------------
// interval_sched_pkg
//   Shared definitions for the interval scheduler slice:
//     - state_t       : scheduler FSM states (also exported for debug)
//     - DEFAULT_N_REQ : default number of requesters
//     - DEFAULT_CNT_W : default counter width
//     - clog2()       : ceiling log2, never less than 1 (index widths)
// ----------------------------------------------------------------------------
package interval_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam int DEFAULT_N_REQ = 4;
  localparam int DEFAULT_CNT_W = 4;

  // Minimum of 1 so a 1-bit index still exists for degenerate sizes.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/interval_sched_if.sv
// ----------------------------------------------------------------------------
// interval_sched_if
//   Bundle between the requesting control logic (master) and the scheduler
//   (slave).
//
//   Handshake: req[i] is a level request. The requester raises it with its
//   length on req_len[i*CNT_W +: CNT_W] and keeps it high until it sees done
//   (or abort) while it owns grant. The length is sampled only on the cycle
//   the request is granted. grant is the one-hot acknowledgement of ownership;
//   dropping req[i] while owning grant aborts the interval. pause is a global
//   hold that freezes the running interval.
//
//   Signals
//     req      master->slave  N_REQ        level requests
//     req_len  master->slave  N_REQ*CNT_W  packed interval lengths
//     pause    master->slave  1            global hold
//     grant    slave->master  N_REQ        one-hot owner in RUN/DONE
//     busy     slave->master  1            RUN or DONE
//     count    slave->master  CNT_W        live counter, 0 when idle
//     done     slave->master  1            completion pulse
//     abort    slave->master  1            owner-dropped pulse
//     owner_id slave->master  ID_W         current/last owner index
// ----------------------------------------------------------------------------
interface interval_sched_if #(
  parameter int N_REQ = interval_sched_pkg::DEFAULT_N_REQ,
  parameter int CNT_W = interval_sched_pkg::DEFAULT_CNT_W
);
  localparam int ID_W = interval_sched_pkg::clog2(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] req_len;
  logic                   pause;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic [CNT_W-1:0]       count;
  logic                   done;
  logic                   abort;
  logic [ID_W-1:0]        owner_id;

  modport master (
    output req, req_len, pause,
    input  grant, busy, count, done, abort, owner_id
  );

  modport slave (
    input  req, req_len, pause,
    output grant, busy, count, done, abort, owner_id
  );

endinterface

// File: rtl/interval_sched_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
//   Combinational round-robin pick. Scans i_last+1, i_last+2, ... (mod N_REQ)
//   and selects the first asserted request.
//
//   Ports
//     i_req    in   N_REQ  request vector
//     i_last   in   ID_W   index of the previous winner
//     o_gnt    out  N_REQ  one-hot winner (0 when no request)
//     o_idx    out  ID_W   winner index (0 when no request)
//     o_valid  out  1      at least one request present
// ----------------------------------------------------------------------------
module rr_arbiter
  import interval_sched_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int ID_W  = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [ID_W-1:0]  i_last,
  output logic [N_REQ-1:0] o_gnt,
  output logic [ID_W-1:0]  o_idx,
  output logic             o_valid
);

  // Scan from the farthest position toward the nearest one; a later hit
  // overwrites an earlier one, so the nearest requester after i_last wins
  // without needing a break.
  always_comb begin
    int j;
    j       = 0;
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = (int'(i_last) + k) % N_REQ;
      if (i_req[j]) begin
        o_gnt    = '0;
        o_gnt[j] = 1'b1;
        o_idx    = ID_W'(j);
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interval_sched.sv
// ----------------------------------------------------------------------------
// interval_sched
//   Shares one up-counter between N_REQ requesters. A winner picked
//   round-robin gets an interval of len+1 unpaused RUN cycles, then a one
//   cycle done pulse. Dropping the request mid-interval yields a one cycle
//   abort pulse instead. At least one IDLE cycle separates intervals.
//
//   Ports
//     clk      in   1       clock, posedge
//     rst      in   1       synchronous active-high reset
//     bus      slave        interval_sched_if (req/req_len/pause in,
//                           grant/busy/count/done/abort/owner_id out)
//     o_state  out  state_t current FSM state (debug)
// ----------------------------------------------------------------------------
module interval_sched
  import interval_sched_pkg::*;
#(
  parameter int N_REQ = DEFAULT_N_REQ,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  interval_sched_if.slave   bus,
  output state_t            o_state
);

  localparam int ID_W = clog2(N_REQ);

  state_t             r_state;
  logic [CNT_W-1:0]   r_count;
  logic [CNT_W-1:0]   r_len;
  logic [ID_W-1:0]    r_owner;
  logic [ID_W-1:0]    r_last;
  logic [N_REQ-1:0]   r_grant;
  logic               r_busy;
  logic               r_done;
  logic               r_abort;

  logic [N_REQ-1:0]   w_gnt;
  logic [ID_W-1:0]    w_idx;
  logic               w_valid;
  logic [CNT_W-1:0]   w_len_sel;
  logic               w_owner_req;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .i_req   (bus.req),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_valid (w_valid)
  );

  assign w_len_sel   = bus.req_len[int'(w_idx)*CNT_W +: CNT_W];
  assign w_owner_req = bus.req[r_owner];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_len   <= '0;
      r_owner <= '0;
      r_last  <= ID_W'(N_REQ - 1);   // requester 0 gets first priority
      r_grant <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_valid) begin
            r_state <= S_RUN;
            r_owner <= w_idx;
            r_last  <= w_idx;
            r_len   <= w_len_sel;
            r_grant <= w_gnt;
            r_busy  <= 1'b1;
            r_count <= '0;
          end
        end

        S_RUN: begin
          // Owner loss beats pause and completion.
          if (!w_owner_req) begin
            r_state <= S_ABORT;
            r_abort <= 1'b1;
            r_grant <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
          end else if (bus.pause) begin
            r_count <= r_count;
          end else if (r_count == r_len) begin
            // count stays at len during the DONE cycle
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_grant <= '0;
          r_busy  <= 1'b0;
          r_count <= '0;
        end

        S_ABORT: begin
          r_state <= S_IDLE;
          r_abort <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.busy     = r_busy;
  assign bus.count    = r_count;
  assign bus.done     = r_done;
  assign bus.abort    = r_abort;
  assign bus.owner_id = r_owner;
  assign o_state      = r_state;

endmodule
